// File: rtl/memory_controller.sv
// Single-port synchronous RAM behind a request/ready handshake.
// A request is captured in IDLE, optionally delayed by WAIT_STATES cycles, then performed in ACCESS.
module memory_controller #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read_en,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  ready
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  // Counter is loaded with WAIT_STATES-1 so ACCESS lands exactly WAIT_STATES edges after capture.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS
  } state_t;

  state_t                  state, state_nxt;
  logic [3:0]              cnt, cnt_nxt;
  logic                    capture;
  logic [ADDR_WIDTH-1:0]   addr_p0;
  logic [DATA_WIDTH-1:0]   data_p0;
  logic                    wr_p0;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if (write_en || read_en) begin
          capture = 1'b1;
          if (WAIT_STATES > 0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = WAIT_LOAD;
          end else begin
            state_nxt = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) state_nxt = S_ACCESS;
        else             cnt_nxt   = cnt - 4'd1;
      end
      S_ACCESS: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      ready <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ready <= (state == S_ACCESS);
    end
  end

  // Stage p0: request capture; only meaningful once IDLE has accepted a request.
  always_ff @(posedge clk) begin
    if (capture) begin
      addr_p0 <= addr;
      data_p0 <= data_in;
      wr_p0   <= write_en;
    end
  end

  // Stage access: storage update or registered read; reset abandons any pending access.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == S_ACCESS) begin
      if (wr_p0) mem[addr_p0] <= data_p0;
      else       data_out     <= mem[addr_p0];
    end
  end

endmodule

// File: tb/tb_memory_controller.sv
// Bench for memory_controller: one instance without wait states, one with two,
// compared against a transaction-level memory model.
module tb_memory_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       re  [2];
  logic       we  [2];
  logic [7:0] ad  [2];
  logic [7:0] di  [2];
  logic [7:0] dq  [2];
  logic       rdy [2];

  int checks = 0;
  int errors = 0;

  logic [7:0] mm [2][256];
  logic [7:0] dm [2];

  always #5 clk = ~clk;

  memory_controller #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_STATES(0)) u0 (
    .clk(clk), .reset(reset), .read_en(re[0]), .write_en(we[0]),
    .data_in(di[0]), .addr(ad[0]), .data_out(dq[0]), .ready(rdy[0]));

  memory_controller #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_STATES(2)) u2 (
    .clk(clk), .reset(reset), .read_en(re[1]), .write_en(we[1]),
    .data_in(di[1]), .addr(ad[1]), .data_out(dq[1]), .ready(rdy[1]));

  typedef struct {
    bit         wr;
    bit         rd;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++) mm[d][i] = 8'h00;
      dm[d] = 8'h00;
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk("reset_ready", {7'b0, rdy[d]}, 8'h00);
        chk("reset_dout", dq[d], 8'h00);
      end
    end
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("post_reset_ready", {7'b0, rdy[d]}, 8'h00);
      chk("post_reset_dout", dq[d], 8'h00);
    end
  endtask

  // Drives one request at the current negedge and follows it to completion.
  // Expected latency is 1 + wait states; ready must be low before and high exactly then.
  task automatic xact(input int d, input bit wr, input bit rd, input logic [7:0] a,
                      input logic [7:0] dat, input bit poke, output logic [7:0] got);
    int lat;
    lat = (d == 1) ? 3 : 1;
    we[d] = wr; re[d] = rd; ad[d] = a; di[d] = dat;
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      if (k == 0) begin
        we[d] = 1'b0; re[d] = 1'b0; ad[d] = 8'($urandom); di[d] = 8'($urandom);
      end
      if (poke && k == 1) begin
        we[d] = 1'b1; ad[d] = a; di[d] = ~dat;
      end
      if (poke && k == 2) we[d] = 1'b0;
      chk("ready_timing", {7'b0, rdy[d]}, (k == lat) ? 8'h01 : 8'h00);
    end
    if (wr) mm[d][a] = dat;
    else    dm[d]    = mm[d][a];
    chk("data_out", dq[d], dm[d]);
    got = dq[d];
  endtask

  task automatic idle_check();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("idle_ready", {7'b0, rdy[d]}, 8'h00);
      chk("idle_dout", dq[d], dm[d]);
    end
  endtask

  // Write to addr that is killed by reset after at_k negedges past the capture edge.
  task automatic abort(input int at_k, input logic [7:0] a, input logic [7:0] dat);
    logic [7:0] got;
    we[1] = 1'b1; ad[1] = a; di[1] = dat;
    for (int k = 0; k <= at_k; k++) begin
      @(negedge clk);
      if (k == 0) begin we[1] = 1'b0; ad[1] = 8'h00; di[1] = 8'h00; end
      chk("abort_pre_ready", {7'b0, rdy[1]}, 8'h00);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_ready", {7'b0, rdy[1]}, 8'h00);
    end
    xact(1, 1'b0, 1'b1, a, 8'h00, 1'b0, got);
    chk("abort_read_zero", got, 8'h00);
    idle_check();
  endtask

  vec_t vecs[9];
  logic [7:0] got;

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      re[d] = 1'b0; we[d] = 1'b0; ad[d] = 8'h00; di[d] = 8'h00;
    end
    vecs[0] = '{1'b1, 1'b0, 8'h01, 8'h16, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 8'h02, 8'hAA, 8'h00};
    vecs[2] = '{1'b0, 1'b1, 8'h01, 8'h00, 8'h16};
    vecs[3] = '{1'b0, 1'b1, 8'h02, 8'h00, 8'hAA};
    vecs[4] = '{1'b0, 1'b1, 8'hFF, 8'h00, 8'h00};
    vecs[5] = '{1'b1, 1'b0, 8'hFF, 8'h5A, 8'h00};
    vecs[6] = '{1'b0, 1'b1, 8'hFF, 8'h00, 8'h5A};
    vecs[7] = '{1'b1, 1'b1, 8'h03, 8'h77, 8'h5A};
    vecs[8] = '{1'b0, 1'b1, 8'h03, 8'h00, 8'h77};

    for (int d = 0; d < 2; d++) begin
      do_reset(3);
      for (int i = 0; i < 9; i++) begin
        xact(d, vecs[i].wr, vecs[i].rd, vecs[i].a, vecs[i].d, 1'b0, got);
        chk("vec_dout", got, vecs[i].exp);
      end
      idle_check();
    end

    // Write pulsed while the wait-state instance is busy must be dropped.
    xact(1, 1'b1, 1'b0, 8'h05, 8'h11, 1'b1, got);
    idle_check();
    xact(1, 1'b0, 1'b1, 8'h05, 8'h00, 1'b0, got);
    chk("busy_ignored", got, 8'h11);
    idle_check();

    abort(1, 8'h04, 8'h99);
    abort(2, 8'h04, 8'h99);

    // Back-to-back requests issued on the ready cycle.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 3; i++) xact(d, 1'b1, 1'b0, 8'(20 + i), 8'(8'hC0 + i), 1'b0, got);
      for (int i = 0; i < 3; i++) begin
        xact(d, 1'b0, 1'b1, 8'(20 + i), 8'h00, 1'b0, got);
        chk("b2b_read", got, 8'(8'hC0 + i));
      end
      idle_check();
    end

    for (int n = 0; n < 80; n++) begin
      int  d;
      bit  wr;
      d  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      xact(d, wr, ~wr, 8'($urandom_range(0, 15)), 8'($urandom), 1'b0, got);
      if ($urandom_range(0, 3) == 0) idle_check();
    end
    idle_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
